seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-anode 7-segment displays, the parametrised successor of the single-digit floor decoder. Accepts a packed vector of 4-bit hex/BCD digits, scans them one at a time through active-low anodes at a programmable refresh rate, and decodes each digit to active-low segments. New display data is double-buffered and committed only at frame boundaries, so the floor and state indication never tears mid-scan.

---
 rtl/seg7_scan_driver.sv | 136 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for common-anode 7-segment digits.
// Digit data is double-buffered (shadow -> active) and committed only at the
// frame wrap, so a scan never shows a mix of old and new data.
// Optional feature: define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    load_i,
  output logic                    pending_o,
  output logic                    frame_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              seg_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    tick;
  logic                    wrap;
  logic                    wrap_q;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] sh_dig;
  logic [NUM_DIGITS-1:0]   sh_blk;
  logic [4*NUM_DIGITS-1:0] ac_dig;
  logic [NUM_DIGITS-1:0]   ac_blk;
  logic [NUM_DIGITS-1:0]   lz_blk;
  logic [3:0]              cur_dig;
  logic                    cur_blank;
`ifdef SEG7_LZB_EN
  logic                    seen_nz;
`endif

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = (div_cnt == DIV_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // Refresh divider and digit index; idx advances once per REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= wrap ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Shadow/active buffers: a wrap commits the old shadow even if a load
  // lands on the same edge, leaving the new data pending for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_dig  <= '0;
      sh_blk  <= '1;
      ac_dig  <= '0;
      ac_blk  <= '1;
      pending <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= wrap;
      if (wrap && pending) begin
        ac_dig  <= sh_dig;
        ac_blk  <= sh_blk;
        pending <= 1'b0;
      end
      if (load_i) begin
        sh_dig  <= digits_i;
        sh_blk  <= blank_i;
        pending <= 1'b1;
      end
    end
  end

  // Pick the digit being scanned and decide whether it is dark.
  always_comb begin
    lz_blk = '0;
`ifdef SEG7_LZB_EN
    seen_nz = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (ac_dig[4*k +: 4] != 4'd0) seen_nz = 1'b1;
      lz_blk[k] = ~seen_nz;
    end
`endif
    cur_dig   = ac_dig[4*idx +: 4];
    cur_blank = ac_blk[idx] | lz_blk[idx];
  end

  // Registered display outputs; frame_o lines up with digit 0 of a new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_o    <= '1;
      seg_o   <= 7'h7F;
      frame_o <= 1'b0;
    end else begin
      an_o    <= ~(NUM_DIGITS'(1) << idx);
      seg_o   <= cur_blank ? 7'h7F : seg_decode(cur_dig);
      frame_o <= wrap_q;
    end
  end

  assign pending_o = pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, 4 cycles per digit). The reference
// model derives scan position from elapsed cycles since reset release and
// applies the double-buffer commit rules per clock edge.
module tb_seg7_scan_driver;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FR  = N * DIV;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  digits_i;
  logic [3:0]   blank_i;
  logic         load_i;
  logic         pending_o;
  logic         frame_o;
  logic [3:0]   an_o;
  logic [6:0]   seg_o;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .digits_i(digits_i), .blank_i(blank_i),
    .load_i(load_i), .pending_o(pending_o), .frame_o(frame_o),
    .an_o(an_o), .seg_o(seg_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // model state
  int          n;
  logic [15:0] m_sh_d, m_ac_d;
  logic [3:0]  m_sh_b, m_ac_b;
  logic        m_pend, m_wrap_prev;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_frame, e_pend;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [6:0] model_seg(input logic [15:0] d, input logic [3:0] b, input int k);
    logic [3:0] v;
    int hi;
    v = d[4*k +: 4];
    if (b[k]) return 7'h7F;
`ifdef SEG7_LZB_EN
    hi = 0;
    for (int j = 0; j < N; j++) if (d[4*j +: 4] != 4'd0) hi = j;
    if (k > hi) return 7'h7F;
`else
    hi = 0;
`endif
    return seg_tab[v];
  endfunction

  task automatic model_edge();
    int pos, cidx;
    logic w;
    if (reset) begin
      n = 0; m_sh_d = '0; m_ac_d = '0; m_sh_b = '1; m_ac_b = '1;
      m_pend = 0; m_wrap_prev = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_frame = 0; e_pend = 0;
    end else begin
      pos  = n % FR;
      cidx = pos / DIV;
      w    = (pos == FR - 1);
      e_an    = ~(4'(1) << cidx);
      e_seg   = model_seg(m_ac_d, m_ac_b, cidx);
      e_frame = m_wrap_prev;
      m_wrap_prev = w;
      if (w && m_pend) begin
        m_ac_d = m_sh_d; m_ac_b = m_sh_b; m_pend = 0;
      end
      if (load_i) begin
        m_sh_d = digits_i; m_sh_b = blank_i; m_pend = 1;
      end
      e_pend = m_pend;
      n++;
    end
  endtask

  task automatic check();
    vectors++;
    assert (an_o === e_an) else begin
      errs++; $error("FAIL an_o: observed %h expected %h (n=%0d)", an_o, e_an, n);
    end
    vectors++;
    assert (seg_o === e_seg) else begin
      errs++; $error("FAIL seg_o: observed %h expected %h (n=%0d)", seg_o, e_seg, n);
    end
    vectors++;
    assert (frame_o === e_frame) else begin
      errs++; $error("FAIL frame_o: observed %b expected %b (n=%0d)", frame_o, e_frame, n);
    end
    vectors++;
    assert (pending_o === e_pend) else begin
      errs++; $error("FAIL pending_o: observed %b expected %b (n=%0d)", pending_o, e_pend, n);
    end
  endtask

  task automatic cyc(input logic ld, input logic [15:0] d, input logic [3:0] b);
    load_i = ld; digits_i = d; blank_i = b;
    @(posedge clk);
    model_edge();
    #1;
    check();
    load_i = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 16'hDEAD, 4'hA);
  endtask

  // advance until the next edge is the wrap edge (scan position FR-1)
  task automatic to_wrap_edge();
    int guard = 0;
    while ((n % FR) != FR - 1 && guard < 2 * FR) begin
      cyc(1'b0, 16'h0, 4'h0);
      guard++;
    end
  endtask

  initial begin
    reset = 1'b1; load_i = 1'b0; digits_i = '0; blank_i = '0;
    // reset for 3 cycles
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 4'h0);
    reset = 1'b0;
    // blank scan over one and a half frames
    idle(24);
    // single load mid-frame, watch commit
    cyc(1'b1, 16'h1234, 4'h0);
    idle(2 * FR);
    // two loads before one wrap: last wins
    cyc(1'b1, 16'h0005, 4'h0);
    idle(3);
    cyc(1'b1, 16'h00AF, 4'h0);
    idle(2 * FR);
    // load on the wrap edge while pending is set
    to_wrap_edge();
    idle(2);
    cyc(1'b1, 16'h5678, 4'h0);
    to_wrap_edge();
    cyc(1'b1, 16'h9ABC, 4'h2);
    idle(2 * FR + 3);
    // leading-zero patterns
    cyc(1'b1, 16'h0070, 4'h0);
    idle(2 * FR);
    cyc(1'b1, 16'h0000, 4'h0);
    idle(2 * FR);
    // reset mid-scan with pending set, then confirm no stale commit
    idle(5);
    cyc(1'b1, 16'hCDEF, 4'h0);
    idle(2);
    reset = 1'b1;
    cyc(1'b0, 16'h0, 4'h0);
    reset = 1'b0;
    idle(2 * FR + 2);
    // randomized loads
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0)
        cyc(1'b1, 16'($urandom), 4'($urandom_range(0, 15) < 4 ? $urandom : 0));
      else
        cyc(1'b0, 16'($urandom), 4'($urandom));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        cyc(1'b0, 16'h0, 4'h0);
        reset = 1'b0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
